// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Odd parity expects data^bit == 1, even parity expects 0.
  function automatic logic calc_parity_err(input logic data_xor, input logic par_bit,
                                           input int mode);
    calc_parity_err = ((data_xor ^ par_bit) != (mode == PARITY_ODD));
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw line through two stages.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchroniser registers, reset to line-idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/rx_uart_param.sv
// Parametrised oversampling UART receiver: start detect, LSB-first deframing,
// optional parity, 1/2 stop bits, framing/break status with a one-cycle valid pulse.
module rx_uart_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 rx_Clk,
  input  logic                 i_RX_Rst_n,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [SC_W-1:0]  SC_HALF   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_FULL   = SC_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_SLAST = IDX_W'(STOP_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (rx_Clk),
    .rst_n (i_RX_Rst_n),
    .d     (i_RX_Serial),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 low_q, low_d;
  logic                 line_prev_q, line_prev_d;
  logic [1:0]           settle_q, settle_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_out_q, brk_out_d;
  logic                 busy_q, busy_d;
  logic                 ferr_fin_s;
  logic                 low_fin_s;

  // Next-state, counters, datapath and registered status outputs.
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q + SC_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    low_d      = low_q;
    valid_d    = 1'b0;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    brk_out_d  = brk_out_q;
    ferr_fin_s = ferr_q | ~rx_s;
    low_fin_s  = low_q & ~rx_s;
    settle_d   = {settle_q[0], 1'b1};
    // Until the synchroniser has flushed its reset value, the line history is
    // forced low so a line held low through reset never looks like a start edge.
    if (settle_q[1]) begin
      line_prev_d = rx_s;
    end else begin
      line_prev_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sc_d  = '0;
        idx_d = '0;
        if (line_prev_q && !rx_s) begin
          state_d = ST_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          low_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sc_q == SC_HALF) begin
          sc_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sc_q == SC_FULL) begin
          sc_d    = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          low_d   = low_fin_s;
          if (idx_q == IDX_DLAST) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (sc_q == SC_FULL) begin
          sc_d    = '0;
          perr_d  = calc_parity_err(^shift_q, rx_s, PARITY);
          low_d   = low_fin_s;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (sc_q == SC_FULL) begin
          sc_d = '0;
          if (idx_q == IDX_SLAST) begin
            idx_d      = '0;
            valid_d    = 1'b1;
            byte_d     = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_fin_s;
            brk_out_d  = low_fin_s;
            if (low_fin_s) begin
              state_d = ST_BRK_WAIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            ferr_d = ferr_fin_s;
            low_d  = low_fin_s;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BRK_WAIT: begin
        sc_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BRK_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge rx_Clk or negedge i_RX_Rst_n) begin
    if (!i_RX_Rst_n) begin
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      low_q       <= 1'b0;
      line_prev_q <= 1'b0;
      settle_q    <= 2'b00;
      valid_q     <= 1'b0;
      byte_q      <= '0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      brk_out_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      low_q       <= low_d;
      line_prev_q <= line_prev_d;
      settle_q    <= settle_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
      brk_out_q   <= brk_out_d;
      busy_q      <= busy_d;
    end
  end

  assign o_RX_Valid   = valid_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Break      = brk_out_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_rx_uart_param.sv
// Directed bench for rx_uart_param: five receiver configurations sharing clock and reset,
// each with its own serial line; a negedge monitor counts and captures valid pulses.
module tb_rx_uart_param;

  localparam int OVS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ser [5];
  logic [4:0] valid, perr, ferr, brk, busy;
  logic [7:0] byte_e1, byte_o1, byte_n2;
  logic [4:0] byte_d5;
  logic [8:0] byte_d9;
  logic [8:0] bytes_s [5];

  // lines: 0=8E1, 1=8O1, 2=8N2, 3=5N1, 4=9E1
  int cfg_bits [5] = '{8, 8, 8, 5, 9};
  int cfg_par  [5] = '{2, 1, 0, 0, 2};
  int cfg_stop [5] = '{1, 1, 2, 1, 1};

  rx_uart_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .rx_Clk(clk), .i_RX_Rst_n(rst_n), .i_RX_Serial(ser[0]), .o_RX_Valid(valid[0]),
    .o_RX_Byte(byte_e1), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]),
    .o_Busy(busy[0]));
  rx_uart_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(1), .STOP_BITS(1)) u_o1 (
    .rx_Clk(clk), .i_RX_Rst_n(rst_n), .i_RX_Serial(ser[1]), .o_RX_Valid(valid[1]),
    .o_RX_Byte(byte_o1), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]),
    .o_Busy(busy[1]));
  rx_uart_param #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .rx_Clk(clk), .i_RX_Rst_n(rst_n), .i_RX_Serial(ser[2]), .o_RX_Valid(valid[2]),
    .o_RX_Byte(byte_n2), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]),
    .o_Busy(busy[2]));
  rx_uart_param #(.DATA_BITS(5), .OVERSAMPLE(OVS), .PARITY(0), .STOP_BITS(1)) u_d5 (
    .rx_Clk(clk), .i_RX_Rst_n(rst_n), .i_RX_Serial(ser[3]), .o_RX_Valid(valid[3]),
    .o_RX_Byte(byte_d5), .o_Parity_Err(perr[3]), .o_Frame_Err(ferr[3]), .o_Break(brk[3]),
    .o_Busy(busy[3]));
  rx_uart_param #(.DATA_BITS(9), .OVERSAMPLE(OVS), .PARITY(2), .STOP_BITS(1)) u_d9 (
    .rx_Clk(clk), .i_RX_Rst_n(rst_n), .i_RX_Serial(ser[4]), .o_RX_Valid(valid[4]),
    .o_RX_Byte(byte_d9), .o_Parity_Err(perr[4]), .o_Frame_Err(ferr[4]), .o_Break(brk[4]),
    .o_Busy(busy[4]));

  assign bytes_s[0] = {1'b0, byte_e1};
  assign bytes_s[1] = {1'b0, byte_o1};
  assign bytes_s[2] = {1'b0, byte_n2};
  assign bytes_s[3] = {4'b0000, byte_d5};
  assign bytes_s[4] = byte_d9;

  int         errors = 0;
  int         checks = 0;
  int         vcnt       [5] = '{default: 0};
  int         long_pulse [5] = '{default: 0};
  logic       prev_valid [5] = '{default: 1'b0};
  logic [8:0] cap_byte   [5] = '{default: 9'h000};
  logic       cap_perr   [5] = '{default: 1'b0};
  logic       cap_ferr   [5] = '{default: 1'b0};
  logic       cap_brk    [5] = '{default: 1'b0};

  // Count valid pulses, capture their payload and flag pulses wider than one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (valid[i]) begin
        vcnt[i]     <= vcnt[i] + 1;
        cap_byte[i] <= bytes_s[i];
        cap_perr[i] <= perr[i];
        cap_ferr[i] <= ferr[i];
        cap_brk[i]  <= brk[i];
        if (prev_valid[i]) long_pulse[i] <= long_pulse[i] + 1;
      end
      prev_valid[i] <= valid[i];
    end
  end

  task automatic drive_bit(input int ln, input logic b);
    ser[ln] = b;
    repeat (OVS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ln, input int n);
    ser[ln] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop_vals[j] is the level driven for stop bit j.
  task automatic send_frame(input int ln, input logic [8:0] data, input logic flip_par,
                            input logic [1:0] stop_vals);
    logic p;
    p = 1'b0;
    drive_bit(ln, 1'b0);
    for (int i = 0; i < cfg_bits[ln]; i++) begin
      drive_bit(ln, data[i]);
      p = p ^ data[i];
    end
    if (cfg_par[ln] != 0) drive_bit(ln, p ^ (cfg_par[ln] == 1) ^ flip_par);
    for (int j = 0; j < cfg_stop[ln]; j++) drive_bit(ln, stop_vals[j]);
  endtask

  task automatic check_frame(input string name, input int ln, input int exp_cnt,
                             input logic [8:0] eb, input logic ep, input logic ef,
                             input logic ebrk);
    checks++;
    if (vcnt[ln] !== exp_cnt) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", name, vcnt[ln], exp_cnt);
    end
    checks++;
    if (cap_byte[ln] !== eb) begin
      errors++; $display("FAIL %s byte: got %h expected %h", name, cap_byte[ln], eb);
    end
    checks++;
    if ({cap_perr[ln], cap_ferr[ln], cap_brk[ln]} !== {ep, ef, ebrk}) begin
      errors++;
      $display("FAIL %s perr/ferr/brk: got %b%b%b expected %b%b%b", name,
               cap_perr[ln], cap_ferr[ln], cap_brk[ln], ep, ef, ebrk);
    end
    checks++;
    if (long_pulse[ln] !== 0) begin
      errors++; $display("FAIL %s pulse width: got %0d wide pulses expected 0", name, long_pulse[ln]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) ser[i] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if ({valid, perr, ferr, brk, busy} !== 25'd0) begin
      errors++; $display("FAIL reset status: got %h expected 0", {valid, perr, ferr, brk, busy});
    end
    checks++;
    if ({byte_e1, byte_o1, byte_n2, byte_d5, byte_d9} !== 38'd0) begin
      errors++; $display("FAIL reset bytes: got %h expected 0",
                         {byte_e1, byte_o1, byte_n2, byte_d5, byte_d9});
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_even_parity();
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    idle(0, 20);
    check_frame("8E1 A5", 0, 1, 9'h0A5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++; $display("FAIL 8E1 busy idle: got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_false_start();
    int   base;
    logic seen_busy;
    logic fell;
    base      = vcnt[0];
    seen_busy = 1'b0;
    fell      = 1'b0;
    ser[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy[0]) seen_busy = 1'b1;
    end
    ser[0] = 1'b1;
    for (int i = 0; i < OVS / 2 + 3; i++) begin
      @(negedge clk);
      if (busy[0]) seen_busy = 1'b1;
      else if (seen_busy) fell = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b1) begin
      errors++; $display("FAIL false start busy rise: got %b expected 1", seen_busy);
    end
    checks++;
    if (fell !== 1'b1) begin
      errors++; $display("FAIL false start busy fall: got %b expected 1", fell);
    end
    idle(0, 20);
    checks++;
    if (vcnt[0] !== base) begin
      errors++; $display("FAIL false start valid: got %0d expected %0d", vcnt[0], base);
    end
  endtask

  task automatic test_odd_parity();
    send_frame(1, 9'h03C, 1'b1, 2'b11);
    idle(1, 20);
    check_frame("8O1 3C bad parity", 1, 1, 9'h03C, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_two_stop();
    send_frame(2, 9'h081, 1'b0, 2'b01);
    idle(2, 20);
    check_frame("8N2 81 stop2 low", 2, 1, 9'h081, 1'b0, 1'b1, 1'b0);
    send_frame(2, 9'h07E, 1'b0, 2'b11);
    idle(2, 20);
    check_frame("8N2 7E clean", 2, 2, 9'h07E, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_break();
    int base;
    base = vcnt[0];
    ser[0] = 1'b0;
    repeat (3 * 11 * OVS) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL break busy held: got %b expected 1", busy[0]);
    end
    idle(0, 20);
    check_frame("break", 0, base + 1, 9'h000, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h055, 1'b0, 2'b11);
    idle(0, 20);
    check_frame("after break 55", 0, base + 2, 9'h055, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = vcnt[0];
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    ser[0] = 1'b1;
    repeat (OVS / 2) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid[0], byte_e1, perr[0], ferr[0], brk[0], busy[0]} !== 13'd0) begin
      errors++; $display("FAIL mid-frame reset outputs: got %h expected 0",
                         {valid[0], byte_e1, perr[0], ferr[0], brk[0], busy[0]});
    end
    rst_n = 1'b1;
    idle(0, 30);
    checks++;
    if (vcnt[0] !== base) begin
      errors++; $display("FAIL mid-frame reset valid: got %0d expected %0d", vcnt[0], base);
    end
    send_frame(0, 9'h00F, 1'b0, 2'b11);
    idle(0, 20);
    check_frame("after reset 0F", 0, base + 1, 9'h00F, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] d5 [3] = '{9'h015, 9'h00A, 9'h01F};
    logic [8:0] d9 [3] = '{9'h1A5, 9'h0FF, 9'h100};
    for (int i = 0; i < 3; i++) begin
      send_frame(3, d5[i], 1'b0, 2'b11);
      check_frame("b2b 5N1", 3, i + 1, d5[i], 1'b0, 1'b0, 1'b0);
    end
    idle(3, 20);
    for (int i = 0; i < 3; i++) begin
      send_frame(4, d9[i], 1'b0, 2'b11);
      check_frame("b2b 9E1", 4, i + 1, d9[i], 1'b0, 1'b0, 1'b0);
    end
    idle(4, 20);
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_false_start();
    test_odd_parity();
    test_two_stop();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
